// File: rtl/regfile_writeback_pkg.sv
// Shared register-file encodings and tracked-register index map.
// Used by writeback, decode and the hazard unit.
package regfile_writeback_pkg;

    localparam logic [1:0] SPEC_GPR = 2'b00;
    localparam logic [1:0] SPEC_SP  = 2'b01;
    localparam logic [1:0] SPEC_IH  = 2'b10;
    localparam logic [1:0] SPEC_T   = 2'b11;

    localparam int NUM_TRACKED = 11;
    localparam int IDX_W       = 4;

    typedef logic [IDX_W-1:0] regIdx_t;

    // GPRs occupy 0..7; SP/IH/T follow at 8..10.
    function automatic regIdx_t regIndex(
        input logic [1:0] spec,
        input logic [2:0] rd
    );
        if (spec == SPEC_GPR)
            return {1'b0, rd};
        return 4'd7 + {2'b00, spec};
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write counters per tracked register, with
// sticky protocol-error flag and two busy queries.
module regfile_scoreboard
    import regfile_writeback_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    issueValid,
    input  regIdx_t issueIdx,
    input  logic    retireValid,
    input  regIdx_t retireIdx,
    input  logic    wbWriteValid,
    input  regIdx_t wbIdx,
    input  regIdx_t q1Idx,
    input  regIdx_t q2Idx,
    output logic    q1Busy,
    output logic    q2Busy,
    output logic    sbError
);

    logic [1:0]             cnt [NUM_TRACKED];
    logic [NUM_TRACKED-1:0] incVec;
    logic [NUM_TRACKED-1:0] decVec;
    logic                   m1;
    logic                   m2;

    always_comb begin
        incVec = '0;
        decVec = '0;
        for (int i = 0; i < NUM_TRACKED; i++) begin
            incVec[i] = issueValid && (issueIdx == IDX_W'(i));
            decVec[i] = retireValid && (retireIdx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TRACKED; i++)
                cnt[i] <= 2'd0;
            sbError <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_TRACKED; i++) begin
                unique case ({incVec[i], decVec[i]})
                    2'b10: begin
                        if (cnt[i] == 2'd3)
                            sbError <= 1'b1;
                        else
                            cnt[i] <= cnt[i] + 2'd1;
                    end
                    2'b01: begin
                        if (cnt[i] == 2'd0)
                            sbError <= 1'b1;
                        else
                            cnt[i] <= cnt[i] - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The write in WB lands on this falling edge, ahead of decode's read.
    assign m1 = wbWriteValid && (wbIdx == q1Idx);
    assign m2 = wbWriteValid && (wbIdx == q2Idx);

    assign q1Busy = (cnt[q1Idx] - {1'b0, m1}) != 2'd0;
    assign q2Busy = (cnt[q2Idx] - {1'b0, m2}) != 2'd0;

endmodule

// File: rtl/regfile_writeback.sv
// MEM/WB latch, write-data select and register-file write port,
// plus the pending-write scoreboard used by decode.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_kill,
    input  logic [1:0]        mem_spec,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic              stall,
    input  logic              issue_valid,
    input  logic [1:0]        issue_spec,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [1:0]        q1_spec,
    input  logic [ADDR_W-1:0] q1_rd,
    input  logic [ADDR_W-1:0] q2_rd,
    output logic              q1_busy,
    output logic              q2_busy,
    output logic              regWrite,
    output logic [1:0]        writeSpecReg,
    output logic [ADDR_W-1:0] R3,
    output logic [DATA_W-1:0] inData3,
    output logic              sb_error
);

    logic              wbValid;
    logic              wbRegWrite;
    logic              wbKill;
    logic [1:0]        wbSpec;
    logic [ADDR_W-1:0] wbRd;
    logic [DATA_W-1:0] wbData;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wbValid    <= 1'b0;
            wbRegWrite <= 1'b0;
            wbKill     <= 1'b0;
            wbSpec     <= SPEC_GPR;
            wbRd       <= '0;
            wbData     <= '0;
        end else if (!stall) begin
            wbValid    <= mem_valid;
            wbRegWrite <= mem_reg_write;
            wbKill     <= mem_kill;
            wbSpec     <= mem_spec;
            wbRd       <= mem_rd;
            wbData     <= mem_to_reg ? mem_load_data : mem_alu_result;
        end
    end

    assign regWrite     = wbValid & wbRegWrite & ~wbKill;
    assign writeSpecReg = wbSpec;
    assign R3           = wbRd;
    assign inData3      = wbData;

    regIdx_t issueIdx;
    regIdx_t wbIdx;
    regIdx_t q1Idx;
    regIdx_t q2Idx;
    logic    retireValid;

    assign issueIdx = regIndex(issue_spec, 3'(issue_rd));
    assign wbIdx    = regIndex(wbSpec, 3'(wbRd));
    assign q1Idx    = regIndex(q1_spec, 3'(q1_rd));
    assign q2Idx    = regIndex(SPEC_GPR, 3'(q2_rd));

    // Killed entries still retire; only live writes hide busy.
    assign retireValid = wbValid & wbRegWrite & ~stall;

    regfile_scoreboard u_sb (
        .clk          (CLK),
        .rst          (RST),
        .issueValid   (issue_valid),
        .issueIdx     (issueIdx),
        .retireValid  (retireValid),
        .retireIdx    (wbIdx),
        .wbWriteValid (regWrite),
        .wbIdx        (wbIdx),
        .q1Idx        (q1Idx),
        .q2Idx        (q2Idx),
        .q1Busy       (q1_busy),
        .q2Busy       (q2_busy),
        .sbError      (sb_error)
    );

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side controller for the CPU register file: the MEM/WB pipeline latch, write-data selection and a pending-write scoreboard. It drives the register file's write port (`regWrite`, `writeSpecReg`, `R3`, `inData3`) from the MEM-stage result. It also tells the decode stage, which reads the file, whether a source register still has an in-flight write. The register file samples the write port on the falling edge of `CLK`, so every output here is launched from the rising edge.

## Interface
- `DATA_W`, 16, register data width
- `ADDR_W`, 3, general-register index width (8 GPRs)
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  asynchronous reset, active-high
- `mem_valid`  in  1  MEM stage holds an instruction
- `mem_reg_write`  in  1  instruction writes a register
- `mem_kill`  in  1  squashed instruction: retires from the scoreboard, never writes
- `mem_spec`  in  2  target class: 00 GPR, 01 SP, 10 IH, 11 T
- `mem_rd`  in  ADDR_W  GPR index; ignored unless `mem_spec`=00
- `mem_to_reg`  in  1  1 selects load data, 0 selects ALU result
- `mem_alu_result`, `mem_load_data`  in  DATA_W  candidate write data
- `stall`  in  1  freeze the WB latch
- `issue_valid`  in  1  an instruction that writes a register leaves decode
- `issue_spec`, `issue_rd`  in  2 / ADDR_W  destination of the issued instruction
- `q1_spec`, `q1_rd`  in  2 / ADDR_W  decode source 1 (may be special)
- `q2_rd`  in  ADDR_W  decode source 2 (GPR only)
- `q1_busy`, `q2_busy`  out  1  source has a pending write not yet visible in the file
- `regWrite`, `writeSpecReg`, `R3`, `inData3`  out  1 / 2 / ADDR_W / DATA_W  register-file write port
- `sb_error`  out  1  sticky flag: scoreboard protocol violation

## Operation
- **Register index map.** 11 tracked registers. Index = `rd` when spec=00; index = 7+spec otherwise (SP=8, IH=9, T=10).
- **WB latch.** On a rising edge with `stall`=0, the latch loads:
  - valid, reg_write, kill, spec, rd from the MEM inputs;
  - data = `mem_to_reg ? mem_load_data : mem_alu_result`.
  - With `stall`=1 the latch holds its contents.
- **Write port.** Driven directly from the latch:
  - `regWrite` = valid & reg_write & ~kill;
  - `writeSpecReg` = spec, `R3` = rd, `inData3` = data.
  - While stalled, the port repeats the same write each cycle. This is harmless because the write is idempotent.
- **Scoreboard.** One 2-bit pending counter per tracked register.
  - Increment event: `issue_valid`, for index(`issue_spec`,`issue_rd`).
  - Retire event: latch valid & reg_write & `stall`=0. Killed entries count as retired. Decrement index(latch spec, latch rd).
  - Increment and retire on the same index in the same cycle leaves the counter unchanged.
  - Overflow: increment at count 3 holds the counter at 3 and sets `sb_error`.
  - Underflow: retire at count 0 holds the counter at 0 and sets `sb_error`.
  - `sb_error` clears only on `RST`.
- **Busy query** (combinational). Busy = counter(index) minus m, tested for nonzero.
  - m = 1 when the latch holds a valid, non-killed write to that index, else 0.
  - Rationale: that write lands on this cycle's falling edge, before decode's read settles.
  - A killed latch entry does not reduce busy.
  - `q2_busy` uses spec=00.

## Timing
- **Reset.** Asynchronous assertion and synchronous-style release at the next rising edge.
  - Outputs while `RST`=1: latch invalid, `regWrite`=0, `writeSpecReg`=0, `R3`=0, `inData3`=0, all counters 0, `q1_busy`=`q2_busy`=0, `sb_error`=0.
  - Reset mid-operation discards in-flight writes; no partial write is issued.
- **Latency.** MEM inputs at edge n appear on the write port after edge n. The file writes at the falling edge within cycle n.
- **Scoreboard visibility.**
  - An issue at edge n makes `q*_busy` high from cycle n+1, the earliest the dependent instruction decodes.
  - The matching write makes busy low during its own WB cycle.
- **Stall.** The latch and the retire event are both frozen. Issues still count.

## Structure
- **Shared package.** Holds the spec encodings (SPEC_GPR=00, SPEC_SP=01, SPEC_IH=10, SPEC_T=11), `NUM_TRACKED`=11, and the index-map function. Decode and the hazard unit reuse it.
- **Sub-module `regfile_scoreboard`.** Contains the counters, increment/retire logic, `sb_error` and both query ports.
- **Top level.** The latch and data mux live in the top level.

## Test plan
- **Reset.** Assert `RST` mid-stream with the latch full and counters nonzero. Required: all outputs 0 immediately, and `regWrite` stays 0 on the next falling edge.
- **GPR ALU write.** Issue spec=00 rd=3, then 2 cycles later drive MEM: alu=0x1234, mem_to_reg=0.
  - Required: `q1_busy`(rd3)=1 for 2 cycles.
  - Required in the WB cycle: `regWrite`=1, `R3`=3, `inData3`=0x1234, `q1_busy`=0.
  - Required: counter 0 afterwards.
- **Special-register load.** Drive a load to SP with load=0xBEEF, mem_to_reg=1. Required: `writeSpecReg`=01, `inData3`=0xBEEF, `q1_busy`(spec 01)=0 during WB.
- **Stall.** Hold `stall`=1 for 2 cycles with a write to IH in the latch. Required: port unchanged for 3 cycles and the counter decrements exactly once, on the unstalling edge.
- **Kill.** Drive a killed write to rd=5. Required: `regWrite`=0 and the counter for rd=5 returns to 0.
- **Scoreboard limits.**
  - 4 issues to T with no retire: counter=3, `sb_error`=1.
  - After reset, same-cycle issue and retire to rd=2 at count 1: count stays 1, `sb_error`=0.
